// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / REQ / RESP)
//   OWNER_*     : requester ids, also used as the round-robin "last owner" bit
//   MASK_NONE   : byte-enable value latched for fetches (they never write)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic       OWNER_IFU = 1'b0;
    localparam logic       OWNER_LSU = 1'b1;
    localparam logic [3:0] MASK_NONE = 4'h0;

endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: combinational two-way round-robin picker.
//   req[1:0]   : in  request vector, bit 0 = IFU, bit 1 = LSU
//   last_owner : in  requester served by the previous grant
//   gnt_valid  : out at least one request is present
//   gnt_id     : out id of the requester to serve (0 = IFU, 1 = LSU)
import mem_arb_pkg::*;

module rr_grant2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = OWNER_IFU;
        if (req == 2'b11) begin
            // Contention: whoever was not served last time goes first.
            gnt_id = ~last_owner;
        end else if (req[1]) begin
            gnt_id = OWNER_LSU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IFU)
// and load/store (LSU), one transaction outstanding at a time.
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   ifu_req/ifu_addr/ifu_flush    : fetch request, address, redirect flush
//   ifu_rvalid/ifu_rdata/ifu_err  : fetch response strobe, data, timeout error
//   lsu_req/lsu_wen/lsu_addr/
//   lsu_wdata/lsu_wmask           : load/store request and payload
//   lsu_rvalid/lsu_rdata/lsu_err  : load/store response strobe, data, error
//   mem_req/mem_addr/mem_wen/
//   mem_wdata/mem_wmask           : memory request and registered payload
//   mem_gnt/mem_rvalid/mem_rdata  : memory accept, response strobe, read data
//   owner                         : current or last owner (0 = IFU, 1 = LSU)
//   busy                          : a transaction is in flight
//
// Handshake semantics: a requester raises *_req and holds it (with a stable
// payload) until its one-cycle *_rvalid strobe; the payload is captured at
// the grant edge, so later changes or a dropped req do not affect the
// transaction. On the memory side mem_req is held from the cycle after the
// grant until the first cycle mem_gnt is high (that cycle is the transfer);
// the response is the first cycle mem_rvalid is high afterwards. If neither
// completes within TIMEOUT_CYCLES cycles of the grant, an error response is
// returned to the owner instead.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RST_OWNER      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    input  logic        ifu_flush,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        owner,
    output logic        busy
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state, state_nxt;
    logic             last_owner;
    logic             discard;
    logic [CNT_W-1:0] cnt;
    logic             gnt_valid, gnt_id;
    logic             grant, timeout, done_ok, done_to, done;
    logic             ifu_hit, lsu_hit;

    rr_grant2 u_rr_grant2 (
        .req        ({lsu_req, ifu_req}),
        .last_owner (last_owner),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign grant   = (state == IDLE) && gnt_valid;
    assign timeout = (state != IDLE) && (cnt == CNT_LAST);
    // A real response arriving on the timeout cycle wins over the error.
    assign done_ok = (state == RESP) && mem_rvalid;
    assign done_to = timeout && !done_ok;
    assign done    = done_ok || done_to;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (gnt_valid) state_nxt = REQ;
            REQ: begin
                if (timeout)      state_nxt = IDLE;
                else if (mem_gnt) state_nxt = RESP;
            end
            RESP: if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: responses are routed combinationally from the memory side.
    // A flushed fetch (flag set earlier, or flush arriving this very cycle)
    // completes on the memory side but is never strobed to the IFU.
    always_comb begin
        mem_req    = (state == REQ);
        busy       = (state != IDLE);
        ifu_hit    = done && (last_owner == OWNER_IFU) && !discard && !ifu_flush;
        lsu_hit    = done && (last_owner == OWNER_LSU);
        ifu_rvalid = ifu_hit;
        ifu_err    = ifu_hit && done_to;
        ifu_rdata  = (ifu_hit && done_ok) ? mem_rdata : 32'h0;
        lsu_rvalid = lsu_hit;
        lsu_err    = lsu_hit && done_to;
        lsu_rdata  = (lsu_hit && done_ok) ? mem_rdata : 32'h0;
    end

    assign owner = last_owner;

    // Grant capture, timeout counter and flush bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= RST_OWNER;
            cnt        <= '0;
            discard    <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wen    <= 1'b0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= MASK_NONE;
        end else begin
            if (grant) begin
                last_owner <= gnt_id;
                cnt        <= '0;
                discard    <= 1'b0;
                if (gnt_id == OWNER_LSU) begin
                    mem_addr  <= lsu_addr;
                    mem_wen   <= lsu_wen;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wmask;
                end else begin
                    mem_addr  <= ifu_addr;
                    mem_wen   <= 1'b0;
                    mem_wdata <= 32'h0;
                    mem_wmask <= MASK_NONE;
                end
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(1);
                if (done) begin
                    discard <= 1'b0;
                end else if (ifu_flush && (last_owner == OWNER_IFU)) begin
                    discard <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// against a transaction-level reference model (round-robin winner, response
// cycle = min(gnt delay + 1 + rvalid delay, TIMEOUT-1), error if later).
module tb_mem_port_arbiter;

    localparam int T = 8;

    logic        clk, rst;
    logic        ifu_req, ifu_flush, ifu_rvalid, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req, lsu_wen, lsu_rvalid, lsu_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req, mem_wen, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        owner, busy;

    int checks   = 0;
    int failures = 0;
    bit m_last   = 1'b0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(T), .RST_OWNER(1'b0)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_flush(ifu_flush),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_gap_busy", {31'b0, busy}, 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    // One complete transaction, starting and ending 1 time unit after an edge.
    task automatic do_txn(input bit ifu_on, input bit lsu_on, input int gnt_dly,
                          input int rv_dly, input int flush_at, input bit flush_idle,
                          input bit drop_early, input logic [31:0] i_addr,
                          input logic [31:0] l_addr, input bit l_wen,
                          input logic [31:0] l_wdata, input logic [3:0] l_mask,
                          input logic [31:0] rdata);
        bit          win, err, supp;
        int          r, done_c;
        logic [31:0] e_addr, e_wdata;
        logic        e_wen;
        logic [3:0]  e_mask;

        ifu_req   = ifu_on;
        lsu_req   = lsu_on;
        ifu_addr  = i_addr;
        lsu_addr  = l_addr;
        lsu_wen   = l_wen;
        lsu_wdata = l_wdata;
        lsu_wmask = l_mask;
        ifu_flush = flush_idle;

        win     = (ifu_on && lsu_on) ? !m_last : lsu_on;
        r       = gnt_dly + 1 + rv_dly;
        done_c  = (r < T - 1) ? r : T - 1;
        err     = (r > T - 1);
        supp    = !win && (flush_at >= 0) && (flush_at <= done_c);
        e_addr  = win ? l_addr : i_addr;
        e_wen   = win ? l_wen : 1'b0;
        e_mask  = win ? l_mask : 4'h0;
        e_wdata = l_wdata;

        @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'h0);
        chk("idle_mem_req", {31'b0, mem_req}, 32'h0);
        chk("idle_owner", {31'b0, owner}, {31'b0, m_last});
        @(posedge clk);
        m_last = win;
        #1;
        for (int c = 0; c <= done_c; c++) begin
            mem_gnt    = (c == gnt_dly);
            mem_rvalid = (c == r);
            mem_rdata  = (c == r) ? rdata : $urandom;
            ifu_flush  = (c == flush_at);
            if (c == 0 && drop_early) begin
                if (win) lsu_req = 1'b0;
                else     ifu_req = 1'b0;
            end
            if (c == 1) begin
                ifu_addr  = $urandom;
                lsu_addr  = $urandom;
                lsu_wdata = $urandom;
                lsu_wen   = ($urandom_range(0, 1) == 1);
                lsu_wmask = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            chk("mem_req", {31'b0, mem_req}, {31'b0, (c <= gnt_dly)});
            chk("busy", {31'b0, busy}, 32'h1);
            chk("owner", {31'b0, owner}, {31'b0, win});
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wen", {31'b0, mem_wen}, {31'b0, e_wen});
            chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, e_mask});
            if (win) chk("mem_wdata", mem_wdata, e_wdata);
            if (c < done_c) begin
                chk("ifu_rvalid_early", {31'b0, ifu_rvalid}, 32'h0);
                chk("lsu_rvalid_early", {31'b0, lsu_rvalid}, 32'h0);
            end else if (win) begin
                chk("lsu_rvalid", {31'b0, lsu_rvalid}, 32'h1);
                chk("lsu_err", {31'b0, lsu_err}, {31'b0, err});
                chk("lsu_rdata", lsu_rdata, err ? 32'h0 : rdata);
                chk("ifu_rvalid_nonowner", {31'b0, ifu_rvalid}, 32'h0);
            end else begin
                chk("ifu_rvalid", {31'b0, ifu_rvalid}, {31'b0, !supp});
                if (!supp) begin
                    chk("ifu_err", {31'b0, ifu_err}, {31'b0, err});
                    chk("ifu_rdata", ifu_rdata, err ? 32'h0 : rdata);
                end
                chk("lsu_rvalid_nonowner", {31'b0, lsu_rvalid}, 32'h0);
            end
            @(posedge clk);
            #1;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        ifu_flush  = 1'b0;
        if (win) lsu_req = 1'b0;
        else     ifu_req = 1'b0;
    endtask

    initial begin
        bit          i_on, l_on;
        int          gd, rd, fa;
        rst        = 1'b1;
        ifu_req    = 1'b0; ifu_addr  = 32'h0; ifu_flush = 1'b0;
        lsu_req    = 1'b0; lsu_wen   = 1'b0; lsu_addr  = 32'h0;
        lsu_wdata  = 32'h0; lsu_wmask = 4'h0;
        mem_gnt    = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_owner", {31'b0, owner}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rvalids", {30'b0, ifu_rvalid, lsu_rvalid}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic fetch, zero-wait memory
        do_txn(1, 0, 0, 0, -1, 0, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 32'h0000_0413);

        // Contention: alternate LSU, IFU, LSU, IFU
        for (int k = 0; k < 4; k++)
            do_txn(1, 1, 0, 0, -1, 0, 0, 32'h8000_0004 + 32'(k * 4), 32'h8000_2000 + 32'(k * 4),
                   1'(k), $urandom, 4'h3, $urandom);

        // Store with delayed grant
        do_txn(0, 1, 3, 0, -1, 0, 0, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 32'h0);

        // Timeout in RESP, rvalid coinciding with timeout, timeout in REQ
        do_txn(0, 1, 0, 50, -1, 0, 0, 32'h0, 32'h8000_1004, 0, 32'h0, 4'h0, 32'h1234_5678);
        idle(1);
        do_txn(0, 1, 0, 6, -1, 0, 0, 32'h0, 32'h8000_1008, 0, 32'h0, 4'h0, 32'hCAFE_F00D);
        do_txn(1, 0, 20, 0, -1, 0, 0, 32'h8000_0040, 32'h0, 0, 32'h0, 4'h0, 32'h5555_AAAA);

        // Flush in RESP, then a normal fetch, then flush coinciding with rvalid
        do_txn(1, 0, 0, 2, 2, 0, 0, 32'h8000_0080, 32'h0, 0, 32'h0, 4'h0, 32'h1111_2222);
        do_txn(1, 0, 0, 1, -1, 0, 0, 32'h9000_0000, 32'h0, 0, 32'h0, 4'h0, 32'h3333_4444);
        do_txn(1, 0, 1, 1, 3, 0, 0, 32'h9000_0004, 32'h0, 0, 32'h0, 4'h0, 32'h6666_7777);
        do_txn(1, 0, 0, 0, -1, 1, 0, 32'h9000_0008, 32'h0, 0, 32'h0, 4'h0, 32'h8888_9999);

        // Reset while in RESP
        ifu_req  = 1'b1;
        ifu_addr = 32'h8000_0100;
        @(posedge clk);
        #1 mem_gnt = 1'b1;
        @(negedge clk);
        chk("pre_rst_mem_req", {31'b0, mem_req}, 32'h1);
        @(posedge clk);
        #1 mem_gnt = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'h1);
        #2 rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        #1;
        chk("mid_rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        chk("mid_rst_owner", {31'b0, owner}, 32'h0);
        chk("mid_rst_ifu_rvalid", {31'b0, ifu_rvalid}, 32'h0);
        chk("mid_rst_ifu_rdata", ifu_rdata, 32'h0);
        ifu_req    = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_last = 1'b0;
        do_txn(1, 0, 0, 0, -1, 0, 0, 32'h8000_0100, 32'h0, 0, 32'h0, 4'h0, 32'h0000_0013);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            i_on = ($urandom_range(0, 1) == 1);
            l_on = i_on ? ($urandom_range(0, 1) == 1) : 1'b1;
            gd   = int'($urandom_range(0, 3));
            rd   = ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 4));
            fa   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            do_txn(i_on, l_on, gd, rd, fa, ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 3) == 0), $urandom, $urandom,
                   ($urandom_range(0, 1) == 1), $urandom, 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
